// File: rtl/gf_serial_mult_pkg.sv
// ============================================================================
// Module   : gfm_pkg
// Brief    : Shared types and defaults for the serial GF(2^WIDTH) multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gfm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gfm_state_t;

    localparam int         GFM_WIDTH    = 8;
    localparam logic [7:0] GFM_AES_POLY = 8'h1B;

endpackage

`default_nettype wire

// File: rtl/gf_serial_mult_if.sv
// ============================================================================
// Module   : gf_serial_mult_if
// Brief    : Operand/product valid-ready bundle for gf_serial_mult.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gf_serial_mult_if
    import gfm_pkg::*;
#(
    parameter int WIDTH = GFM_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_p;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface

`default_nettype wire

// File: rtl/gf_serial_mult_xtime.sv
// ============================================================================
// Module   : gf_xtime
// Brief    : Combinational multiply-by-x with polynomial reduction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_xtime
    import gfm_pkg::*;
#(
    parameter int               WIDTH = GFM_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(GFM_AES_POLY)
) (
    input  wire logic [WIDTH-1:0] i_a,
    output logic      [WIDTH-1:0] o_x
);
    // The reduction decision uses the bit about to be shifted out.
    assign o_x = {i_a[WIDTH-2:0], 1'b0} ^ (i_a[WIDTH-1] ? POLY : '0);
endmodule

`default_nettype wire

// File: rtl/gf_serial_mult.sv
// ============================================================================
// Module   : gf_serial_mult
// Brief    : Bit-serial GF(2^WIDTH) multiplier, one shift-and-XOR per clock.
//            Optional macro GFM_EARLY_TERM_EN stops once the multiplier is used up.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_serial_mult
    import gfm_pkg::*;
#(
    parameter int               WIDTH = GFM_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(GFM_AES_POLY)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    gf_serial_mult_if.slave   bus
);
    localparam int         c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    gfm_state_t         r_state;
    gfm_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]   r_out_p;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   w_a_x;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [WIDTH-1:0]   w_p_nxt;
    logic               w_accept;
    logic               w_last;

    gf_xtime #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_xtime (
        .i_a (r_a),
        .o_x (w_a_x)
    );

    assign w_b_nxt  = r_b >> 1;
    assign w_p_nxt  = r_b[0] ? (r_p ^ r_a) : r_p;
    assign w_accept = bus.in_valid && (r_state == IDLE);

`ifdef GFM_EARLY_TERM_EN
    // A zero multiplier also passes through one RUN step, giving a 1-edge latency.
    assign w_last = (r_cnt == c_CNT_LAST) || (w_b_nxt == '0);
`else
    assign w_last = (r_cnt == c_CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_state_nxt = RUN;
            RUN:     if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_out_p <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.in_a;
                        r_b   <= bus.in_b;
                        r_p   <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_p   <= w_p_nxt;
                    r_a   <= w_a_x;
                    r_b   <= w_b_nxt;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        r_out_p <= w_p_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_p     = r_out_p;
endmodule

`default_nettype wire

// File: tb/tb_gf_serial_mult.sv
// ============================================================================
// Module   : tb_gf_serial_mult
// Brief    : Self-checking bench for gf_serial_mult against a GF(2^8) model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf_serial_mult;
    import gfm_pkg::*;

    localparam int         c_W    = 8;
    localparam logic [7:0] c_POLY = 8'h1B;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    gf_serial_mult_if #(.WIDTH(c_W)) bus ();

    gf_serial_mult #(.WIDTH(c_W), .POLY(c_POLY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry-less full product, then long division by x^8 + POLY.
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        logic [15:0] m;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        m = {7'd0, 1'b1, c_POLY};
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (m << (i - 8));
        return prod[7:0];
    endfunction

    function automatic int exp_lat(input logic [7:0] b);
`ifdef GFM_EARLY_TERM_EN
        int msb;
        msb = 0;
        for (int i = 0; i < 8; i++)
            if (b[i]) msb = i;
        return (b == 8'd0) ? 1 : msb + 1;
`else
        return c_W;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand pair, returns once out_valid is visible.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output bit busy_ok);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom();
        bus.in_b     = $urandom();
        busy_ok      = bus.busy;
        lat          = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
            busy_ok = busy_ok && bus.busy;
        end
        if (!bus.out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL op_timeout: out_valid=%0b after %0d edges, required 1", bus.out_valid, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_p} !== {3'b100, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state: rdy/vld/busy/p=%b/%b/%b/%h, required 1/0/0/00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_p);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        bus.out_ready = 1'b0;
        run_op(8'h57, 8'h83, lat, bok);
        n_vec++;
        if (bus.out_p !== 8'hC1) begin
            n_err++; $display("FAIL basic_p: got %h, required c1", bus.out_p);
        end
        n_vec++;
        if (lat !== c_W) begin
            n_err++; $display("FAIL basic_latency: got %0d, required %0d", lat, c_W);
        end
        n_vec++;
        if (!bok) begin
            n_err++; $display("FAIL basic_busy: busy dropped during op, required held 1");
        end
        bus.out_ready = 1'b1;
        tick();
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_p} !== {3'b100, 8'hC1}) begin
            n_err++;
            $display("FAIL basic_release: rdy/vld/busy/p=%b/%b/%b/%h, required 1/0/0/c1",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_p);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        bus.out_ready = 1'b1;
        run_op(8'h53, 8'hCA, lat, bok);
        n_vec++;
        if (bus.out_p !== 8'h01) begin
            n_err++; $display("FAIL b2b_first_p: got %h, required 01", bus.out_p);
        end
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h57;
        bus.in_b     = 8'h13;
        tick();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_no_same_cycle: in_ready=%b out_valid=%b, required 1/0",
                              bus.in_ready, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_second_accept: busy=%b in_ready=%b, required 1/0",
                              bus.busy, bus.in_ready);
        end
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        n_vec++;
        if (bus.out_p !== 8'hFE || lat !== exp_lat(8'h13)) begin
            n_err++; $display("FAIL b2b_second: p=%h lat=%0d, required fe lat=%0d",
                              bus.out_p, lat, exp_lat(8'h13));
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        bit bok;
        bit held;
        bus.out_ready = 1'b0;
        run_op(8'h57, 8'h83, lat, bok);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h02;
        bus.in_b     = 8'h03;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            held = held && (bus.out_p === 8'hC1) && (bus.in_ready === 1'b0)
                        && (bus.out_valid === 1'b1);
        end
        n_vec++;
        if (!held) begin
            n_err++; $display("FAIL bp_hold: p=%h in_ready=%b out_valid=%b, required c1/0/1",
                              bus.out_p, bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        tick();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1/0",
                              bus.in_ready, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        n_vec++;
        if (bus.out_p !== 8'h06) begin
            n_err++; $display("FAIL bp_next_p: got %h, required 06", bus.out_p);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit bok;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'h57;
        bus.in_b      = 8'h83;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_p} !== {3'b100, 8'h00}) begin
            n_err++;
            $display("FAIL rst_mid_run: rdy/vld/busy/p=%b/%b/%b/%h, required 1/0/0/00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_p);
        end
        run_op(8'h02, 8'h80, lat, bok);
        n_vec++;
        if (bus.out_p !== 8'h1B) begin
            n_err++; $display("FAIL reduction_p: got %h, required 1b", bus.out_p);
        end
        tick();
    endtask

    task automatic test_zero_identity();
        logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h3C, 8'h80};
        logic [7:0] vb [4] = '{8'hFF, 8'h01, 8'h00, 8'h80};
        int lat;
        bit bok;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], lat, bok);
            n_vec++;
            if (bus.out_p !== gf_ref(va[i], vb[i]) || lat !== exp_lat(vb[i])) begin
                n_err++;
                $display("FAIL zero_ident[%0d]: %h*%h p=%h lat=%0d, required p=%h lat=%0d",
                         i, va[i], vb[i], bus.out_p, lat, gf_ref(va[i], vb[i]), exp_lat(vb[i]));
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int sent;
        int recv;
        int cyc;
        bit fire_in;
        bit fire_out;
        logic [7:0] exp_p;
        sent = 0;
        recv = 0;
        cyc  = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        while (recv < 1000 && cyc < 60000) begin
            if (sent < 1000 && $urandom_range(3, 0) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_a     = $urandom();
                bus.in_b     = $urandom();
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(2, 0) != 0);
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_in) begin
                q.push_back(gf_ref(bus.in_a, bus.in_b));
                sent++;
            end
            if (fire_out) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: product %h with nothing outstanding, required none",
                             bus.out_p);
                end else begin
                    exp_p = q.pop_front();
                    if (bus.out_p !== exp_p) begin
                        n_err++;
                        $display("FAIL rand_p[%0d]: got %h, required %h", recv, bus.out_p, exp_p);
                    end
                end
                recv++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (recv !== 1000 || sent !== 1000 || q.size() !== 0) begin
            n_err++;
            $display("FAIL rand_count: sent=%0d recv=%0d pending=%0d, required 1000/1000/0",
                     sent, recv, q.size());
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_zero_identity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
